// File: rtl/hyper_mem_responder.sv
// HyperRAM-style target on an oversampled HyperBus: CA decode, initial latency, linear/wrapped bursts.
// Outputs are registered one sys_clk after the triggering ck edge; the initiator owns all pacing.
module hyper_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [15:0] ID0_VAL   = 16'h0C81,
  parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       hyper_reset_ni,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  input  logic       hyper_rwds_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_REGWR, S_IGNORE} state_e;

  logic          rst;
  logic          ck_q, ck_qq, cs_q, rwds_q;
  logic [7:0]    dq_q;
  logic          ck_edge;
  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [39:0]   ca_q, ca_d;
  logic [31:0]   addr_q, addr_d, addr_inc, wrap_mask;
  logic          hi_q, hi_d, rd_q, rd_d, reg_q, reg_d, lin_q, lin_d;
  logic [15:0]   cr0_q, cr0_d;
  logic [7:0]    dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d, rwds_out_q, rwds_out_d, rwds_oe_q, rwds_oe_d;
  logic [2:0]    lat_l;
  logic [4:0]    lat_edges;
  logic [15:0]   reg_word, rd_word;
  logic          mem_we_hi, mem_we_lo;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_q [MEM_WORDS];

  assign rst     = rst_i | ~hyper_reset_ni;
  assign ck_edge = ck_q ^ ck_qq;
  assign mem_idx = addr_q[AW-1:0];

  always_comb begin
    lat_l = 3'd6;
    unique case (cr0_q[7:4])
      4'b0000: lat_l = 3'd5;
      4'b1110: lat_l = 3'd3;
      4'b1111: lat_l = 3'd4;
      default: lat_l = 3'd6;
    endcase
  end
  assign lat_edges = cr0_q[3] ? {lat_l, 2'b00} : {1'b0, lat_l, 1'b0};

  always_comb begin
    unique case (cr0_q[1:0])
      2'b00:   wrap_mask = 32'd63;
      2'b01:   wrap_mask = 32'd31;
      2'b10:   wrap_mask = 32'd7;
      default: wrap_mask = 32'd15;
    endcase
  end
  assign addr_inc = lin_q ? addr_q + 32'd1
                          : (addr_q & ~wrap_mask) | ((addr_q + 32'd1) & wrap_mask);

  always_comb begin
    reg_word = 16'h0000;
    if (addr_q == 32'h0000_0000)      reg_word = ID0_VAL;
    else if (addr_q == 32'h0000_0800) reg_word = cr0_q;
  end
  assign rd_word = reg_q ? reg_word : mem_q[mem_idx];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ca_d       = ca_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    lin_d      = lin_q;
    cr0_d      = cr0_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
    rwds_out_d = rwds_out_q;
    rwds_oe_d  = rwds_oe_q;
    mem_we_hi  = 1'b0;
    mem_we_lo  = 1'b0;
    // Deselect beats any edge seen in the same cycle.
    if (cs_q) begin
      state_d   = S_IDLE;
      dq_oe_d   = 1'b0;
      rwds_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d    = S_CA;
          cnt_d      = 5'd0;
          dq_oe_d    = 1'b0;
          rwds_oe_d  = 1'b1;
          rwds_out_d = cr0_q[3];
        end
        S_CA: begin
          rwds_oe_d  = 1'b1;
          rwds_out_d = cr0_q[3];
          if (ck_edge) begin
            ca_d  = {ca_q[31:0], dq_q};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd5) begin
              // Sixth byte is still in dq_q: decode from the first five plus it.
              rd_d      = ca_q[39];
              reg_d     = ca_q[38];
              lin_d     = ca_q[37];
              addr_d    = {ca_q[36:8], dq_q[2:0]};
              cnt_d     = 5'd0;
              hi_d      = 1'b1;
              rwds_oe_d = 1'b0;
              state_d   = (!ca_q[39] && ca_q[38]) ? S_REGWR : S_LAT;
            end
          end
        end
        S_LAT: begin
          if (ck_edge) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == lat_edges - 5'd1) state_d = rd_q ? S_RD : S_WR;
          end
        end
        S_RD: begin
          if (ck_edge) begin
            dq_oe_d    = 1'b1;
            rwds_oe_d  = 1'b1;
            rwds_out_d = hi_q;
            dq_out_d   = hi_q ? rd_word[15:8] : rd_word[7:0];
            hi_d       = ~hi_q;
            if (!hi_q && !reg_q) addr_d = addr_inc;
          end
        end
        S_WR: begin
          dq_oe_d   = 1'b0;
          rwds_oe_d = 1'b0;
          if (ck_edge) begin
            mem_we_hi = hi_q && !rwds_q && !rst;
            mem_we_lo = !hi_q && !rwds_q && !rst;
            hi_d      = ~hi_q;
            if (!hi_q) addr_d = addr_inc;
          end
        end
        S_REGWR: begin
          if (ck_edge) begin
            ca_d = {ca_q[31:0], dq_q};
            hi_d = 1'b0;
            if (!hi_q) begin
              if (addr_q == 32'h0000_0800) cr0_d = {ca_q[7:0], dq_q};
              state_d = S_IGNORE;
            end
          end
        end
        S_IGNORE: begin
          dq_oe_d   = 1'b0;
          rwds_oe_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst) begin
      ck_q       <= 1'b0;
      ck_qq      <= 1'b0;
      cs_q       <= 1'b1;
      dq_q       <= 8'h00;
      rwds_q     <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      ca_q       <= 40'd0;
      addr_q     <= 32'd0;
      hi_q       <= 1'b1;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      lin_q      <= 1'b0;
      cr0_q      <= CR0_RST;
      dq_out_q   <= 8'h00;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      ck_q       <= hyper_ck_i;
      ck_qq      <= ck_q;
      cs_q       <= hyper_cs_ni;
      dq_q       <= hyper_dq_i;
      rwds_q     <= hyper_rwds_i;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ca_q       <= ca_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      lin_q      <= lin_d;
      cr0_q      <= cr0_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // Array is deliberately outside reset so a device reset preserves contents.
  always_ff @(posedge sys_clk_i) begin
    if (mem_we_hi) mem_q[mem_idx][15:8] <= dq_q;
    if (mem_we_lo) mem_q[mem_idx][7:0]  <= dq_q;
  end

  assign hyper_dq_o      = dq_out_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_out_q;
  assign hyper_rwds_oe_o = rwds_oe_q;

endmodule

// File: tb/tb_hyper_mem_responder.sv
// Randomized bench for hyper_mem_responder: acts as HyperBus initiator and compares against a
// transaction-level model of memory, CR0, latency and burst addressing.
module tb_hyper_mem_responder;

  localparam int          MW   = 1024;
  localparam logic [15:0] ID0  = 16'h0C81;
  localparam logic [15:0] CR0R = 16'h8F1F;

  logic       sys_clk = 1'b0;
  logic       rst_i, hyper_reset_ni, cs, ck, rwds_i;
  logic [7:0] dq_i;
  logic [7:0] dq_o;
  logic       dq_oe_o, rwds_o, rwds_oe_o;

  hyper_mem_responder #(.MEM_WORDS(MW), .ID0_VAL(ID0), .CR0_RST(CR0R)) dut (
    .sys_clk_i      (sys_clk),
    .rst_i          (rst_i),
    .hyper_reset_ni (hyper_reset_ni),
    .hyper_cs_ni    (cs),
    .hyper_ck_i     (ck),
    .hyper_dq_i     (dq_i),
    .hyper_rwds_i   (rwds_i),
    .hyper_dq_o     (dq_o),
    .hyper_dq_oe_o  (dq_oe_o),
    .hyper_rwds_o   (rwds_o),
    .hyper_rwds_oe_o(rwds_oe_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [MW];
  logic [15:0] ref_cr0;
  logic [15:0] wdat [64];
  logic        mhi  [64];
  logic        mlo  [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [15:0] c);
    int l;
    case (c[7:4])
      4'h0:    l = 5;
      4'h1:    l = 6;
      4'hE:    l = 3;
      4'hF:    l = 4;
      default: l = 6;
    endcase
    return c[3] ? 4 * l : 2 * l;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input bit lin);
    logic [31:0] g;
    if (lin) return a + 32'd1;
    case (ref_cr0[1:0])
      2'b00:   g = 64;
      2'b01:   g = 32;
      2'b10:   g = 8;
      default: g = 16;
    endcase
    return a - (a % g) + ((a + 32'd1) % g);
  endfunction

  function automatic logic [15:0] reg_val(input logic [31:0] a);
    if (a == 32'h0)   return ID0;
    if (a == 32'h800) return ref_cr0;
    return 16'h0000;
  endfunction

  // One HyperBus ck edge, then enough sys_clk cycles for the target to react.
  task automatic drive_edge(input logic [7:0] d, input logic m);
    dq_i   = d;
    rwds_i = m;
    ck     = ~ck;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic send_ca(input bit rd, input bit rg, input bit lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
    cs = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      drive_edge(ca[47-8*i -: 8], 1'b0);
      if (i == 2) begin
        check("ca_rwds_oe", rwds_oe_o, 1);
        check("ca_rwds", rwds_o, ref_cr0[3]);
      end
    end
  endtask

  task automatic xfer(input bit rd, input bit rg, input bit lin, input logic [31:0] a,
                      input int nw, input bit abort);
    logic [31:0] p;
    logic [15:0] w;
    int          nb, k, lat;
    bit          hb;
    send_ca(rd, rg, lin, a);
    if (!rd && rg) begin
      drive_edge(wdat[0][15:8], 1'b1);
      drive_edge(wdat[0][7:0], 1'b1);
      if (a == 32'h800) ref_cr0 = wdat[0];
    end else begin
      lat = lat_of(ref_cr0);
      for (int i = 0; i < lat; i++) drive_edge(8'h00, 1'b0);
      check("lat_dq_oe", dq_oe_o, 0);
      p  = a;
      nb = 2 * nw - (abort ? 1 : 0);
      for (int b = 0; b < nb; b++) begin
        hb = (b % 2 == 0);
        k  = b / 2;
        if (rd) begin
          w = rg ? reg_val(p) : ref_mem[p % MW];
          drive_edge(8'h00, 1'b0);
          check(hb ? "rd_hi" : "rd_lo", dq_o, hb ? w[15:8] : w[7:0]);
          check("rd_rwds", rwds_o, hb);
          check("rd_oe", {dq_oe_o, rwds_oe_o}, 2'b11);
        end else begin
          drive_edge(hb ? wdat[k][15:8] : wdat[k][7:0], hb ? mhi[k] : mlo[k]);
          if (hb && !mhi[k]) ref_mem[p % MW][15:8] = wdat[k][15:8];
          if (!hb && !mlo[k]) ref_mem[p % MW][7:0] = wdat[k][7:0];
          check("wr_oe", {dq_oe_o, rwds_oe_o}, 2'b00);
        end
        if (!hb && !(rd && rg)) p = adv(p, lin);
      end
    end
    cs = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("end_oe", {dq_oe_o, rwds_oe_o}, 2'b00);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] v);
    wdat[0] = v;
    xfer(1'b0, 1'b1, 1'b1, a, 1, 1'b0);
  endtask

  task automatic reset_mid_read(input bit via_ni);
    int lat;
    send_ca(1'b1, 1'b0, 1'b1, 32'd10);
    lat = lat_of(ref_cr0);
    for (int i = 0; i < lat; i++) drive_edge(8'h00, 1'b0);
    drive_edge(8'h00, 1'b0);
    check("pre_rst_oe", dq_oe_o, 1);
    check("pre_rst_dq", dq_o, ref_mem[10][15:8]);
    if (via_ni) hyper_reset_ni = 1'b0;
    else        rst_i = 1'b1;
    @(negedge sys_clk);
    check("rst_dq_oe", dq_oe_o, 0);
    check("rst_rwds_oe", rwds_oe_o, 0);
    rst_i          = 1'b0;
    hyper_reset_ni = 1'b1;
    cs             = 1'b1;
    ref_cr0        = CR0R;
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          r, nw;
    logic [31:0] a;
    rst_i = 1'b1; hyper_reset_ni = 1'b1; cs = 1'b1; ck = 1'b0; dq_i = 8'h00; rwds_i = 1'b0;
    ref_cr0 = CR0R;
    repeat (3) @(negedge sys_clk);
    check("rst_dq", dq_o, 0);
    check("rst_dq_oe", dq_oe_o, 0);
    check("rst_rwds", rwds_o, 0);
    check("rst_rwds_oe", rwds_oe_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Register space reads: CR0 reset value with 24-edge latency, ID0, unmapped.
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
    xfer(1'b1, 1'b1, 1'b0, 32'h0, 2, 1'b0);
    xfer(1'b1, 1'b1, 1'b1, 32'h123, 1, 1'b0);

    // Fill the whole array so every later read has a defined expectation.
    for (int blk = 0; blk < MW / 64; blk++) begin
      for (int k = 0; k < 64; k++) begin
        wdat[k] = 16'($urandom); mhi[k] = 1'b0; mlo[k] = 1'b0;
      end
      xfer(1'b0, 1'b0, 1'b1, 32'(blk * 64), 64, 1'b0);
    end

    reg_write(32'h800, 16'h8E17);
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
    reg_write(32'h7FF, 16'h1234);
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);

    // Masked linear write at address 5.
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333;
    for (int k = 0; k < 3; k++) begin mhi[k] = 1'b0; mlo[k] = 1'b0; end
    mhi[1] = 1'b1;
    xfer(1'b0, 1'b0, 1'b1, 32'd5, 3, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'd5, 3, 1'b0);

    // 8-word wrap from 0x0E, and linear wrap at the top of the array.
    reg_write(32'h800, 16'h8E16);
    xfer(1'b1, 1'b0, 1'b0, 32'h0E, 10, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'(MW - 1), 2, 1'b0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        reg_write(32'h800, 16'($urandom));
      end else if (r == 1) begin
        a = ($urandom_range(0, 2) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'h800 : $urandom);
        xfer(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom_range(1, 3), 1'b0);
      end else begin
        nw = $urandom_range(1, 16);
        for (int k = 0; k < 16; k++) begin
          wdat[k] = 16'($urandom);
          mhi[k]  = ($urandom_range(0, 3) == 0);
          mlo[k]  = ($urandom_range(0, 3) == 0);
        end
        xfer(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 4 * MW - 1)), nw, 1'b0);
      end
    end

    // Deselect after the high byte of a write keeps only that byte.
    wdat[0] = 16'hA55A; mhi[0] = 1'b0; mlo[0] = 1'b0;
    xfer(1'b0, 1'b0, 1'b1, 32'd40, 1, 1'b1);
    xfer(1'b1, 1'b0, 1'b1, 32'd40, 1, 1'b0);

    reg_write(32'h800, 16'h8E17);
    reset_mid_read(1'b0);
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
    reg_write(32'h800, 16'h8E16);
    reset_mid_read(1'b1);
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'd3, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_mem_responder.md
Name: hyper_mem_responder

Overview:
- Synthesizable HyperRAM-style target that answers the HyperBus initiator on the pad side of the uDMA HyperBus controller.
- Used in FPGA loopback builds and in RTL regression as the far end of the bus. It decodes the 48-bit command/address (CA), applies initial latency, and serves linear or wrapped bursts.
- Backed by an internal 16-bit-wide memory plus an ID0/CR0 register space.
- Oversamples the HyperBus clock on sys_clk_i.

Parameters:
- MEM_WORDS, 1024: depth of the 16-bit memory array. Must be a power of 2.
- ID0_VAL, 16'h0C81: value returned by a register read at address 0.
- CR0_RST, 16'h8F1F: reset value of CR0.

Ports:
- sys_clk_i  in  1  single clock; must be at least 4x the HyperBus ck frequency.
- rst_i  in  1  synchronous, active-high reset.
- hyper_reset_ni  in  1  device reset from initiator; low has the same effect as rst_i, sampled synchronously.
- hyper_cs_ni  in  1  chip select, active low.
- hyper_ck_i  in  1  HyperBus clock, oversampled.
- hyper_dq_i  in  8  DQ from initiator.
- hyper_rwds_i  in  1  RWDS from initiator; acts as the write byte mask.
- hyper_dq_o  out  8  read data.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_o  out  1  RWDS driven by the target.
- hyper_rwds_oe_o  out  1  RWDS output enable.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high (rst_i).
  - hyper_ck_i, hyper_cs_ni and hyper_dq_i are each registered once. An "edge" is ck_q != ck_qq, where ck_qq is one register stage later; rising and falling edges both count.
  - All outputs are registered and update one sys_clk after the edge that triggers them.
  - Reset values: dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0, CR0=CR0_RST, state=IDLE. Memory contents are not reset.
- States: IDLE, CA, LAT, RD, WR, REGWR, IGNORE.
  - cs_q high in any state -> next cycle IDLE, both oe deasserted. This includes mid-burst; a pending half-written word keeps only the bytes already committed.
  - IDLE: cs_q falls -> CA, edge counter=0.
  - CA: capture one byte per edge, MSB byte first, into ca[47:0]. Drive rwds_oe_o=1 throughout CA with rwds_o=CR0[3] (fixed latency forces double latency).
  - After the 6th edge, decode the CA:
    - ca[47]: 1=read, 0=write.
    - ca[46]: 1=register space.
    - ca[45]: 1=linear burst, 0=wrapped burst.
    - Word address = {ca[44:16], ca[2:0]}, taken mod MEM_WORDS for memory.
  - Exit from CA: register write -> REGWR; everything else -> LAT.
- Latency:
  - L is decoded from CR0[7:4]: 0000=5, 0001=6, 1110=3, 1111=4, any other code=6.
  - Double latency applies when CR0[3]=1.
  - LAT counts 2*L edges, or 4*L edges when double, starting after the 6th CA edge. Then go to RD for reads, WR for memory writes.
- RD:
  - Each edge outputs one byte: [15:8] of the current word first, then [7:0].
  - dq_oe_o=1 and rwds_oe_o=1; rwds_o toggles per byte, starting at 1 for the high byte.
  - After the low byte, the address increments.
  - Register reads: address 0 returns ID0_VAL, address 0x800 returns CR0, any other address returns 0. The address does not increment.
- WR:
  - Each edge captures one byte. rwds_q=1 masks that byte; rwds_q=0 writes it.
  - The byte write commits on the same edge it is captured. The address increments after the low byte.
  - rwds_oe_o=0 and dq_oe_o=0 during WR.
- Wrapped bursts (ca[45]=0):
  - Group length from CR0[1:0] in words: 00=64, 01=32, 10=8, 11=16.
  - On increment, the low log2(group) address bits wrap; the upper bits hold.
- Linear bursts and the memory array: the address wraps at MEM_WORDS.
- REGWR:
  - No latency. The next two edges form a word, MSB byte first; rwds is ignored.
  - At register address 0x800 the word loads CR0. Any other address is discarded.
  - Then go to IGNORE.
- IGNORE: ignore all edges until cs_q high.
- Simultaneous events: when cs deassertion coincides with an edge, deassertion wins and that edge is not processed.
- hyper_reset_ni low: same effect as rst_i, except the memory array is kept.

Test Plan:
- Reset, then register read at address 0x800 -> bytes 0x8F,0x1F. rwds during CA = 1. Data starts exactly 24 edges after CA (L=6, double).
- Register write 0x8E17 to address 0x800 -> CR0 reads back 0x8E17. Next memory read starts 12 edges after CA (L=6, single); wrapped group length = 16 words.
- Linear write of words 0x1111,0x2222,0x3333 at address 5, with the rwds mask high on the byte carrying 0x22 -> read-back gives 0x1111, 0xXX22 (high byte unchanged, low byte 0x22), 0x3333.
- CR0[1:0]=10, wrapped read of 10 words starting at address 0x0E -> addresses 0x0E,0x0F,0x08..0x0F.
- Linear read at address MEM_WORDS-1 for 2 words -> second word comes from address 0.
- cs_ni deasserted after the high byte of a write -> high byte committed, low byte unchanged. Outputs are idle one cycle later and the next transaction decodes correctly. Assert rst_i mid-read -> all oe=0 next cycle.
